// File: rtl/ysyx_22040386_if_stage.sv
// Instruction-fetch stage: owns the PC, keeps a single fetch outstanding to instruction memory,
// and holds one fetched instruction for IF/ID. It presents a NOP bubble whenever that buffer is empty.
module ysyx_22040386_if_stage #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_IF_clk,
    input  logic        i_IF_rst,
    input  logic        i_IF_jump_flag,
    input  logic [63:0] i_IF_jump_pc,
    input  logic        i_IF_load_use_flag,
    output logic        o_IF_imem_req,
    output logic [63:0] o_IF_imem_addr,
    input  logic        i_IF_imem_ready,
    input  logic        i_IF_imem_rvalid,
    input  logic [31:0] i_IF_imem_rdata,
    output logic [31:0] o_IF_inst,
    output logic [63:0] o_IF_pc,
    output logic [4:0]  o_IF_reg_rd_addr1,
    output logic [4:0]  o_IF_reg_rd_addr2,
    output logic        o_IF_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state;
    logic [63:0] pc_r;
    logic [63:0] fetch_pc;
    logic [63:0] buf_pc;
    logic [31:0] buf_inst;
    logic        buf_valid;
    logic        drop;

    logic        consume;
    logic        fire;
    logic [63:0] jump_target;

    assign jump_target = i_IF_jump_pc & ~64'h3;
    assign consume     = buf_valid && !i_IF_load_use_flag && !i_IF_jump_flag;

    // A new fetch may only start when the buffer is empty or drains this cycle.
    always_comb begin
        // NOTE: default first, so every path assigns the output and no latch is inferred.
        o_IF_imem_req = 1'b0;
        if (state == REQ) begin
            o_IF_imem_req = !i_IF_jump_flag && (!buf_valid || consume);
        end
    end

    assign fire           = o_IF_imem_req && i_IF_imem_ready;
    assign o_IF_imem_addr = pc_r;

    always_ff @(posedge i_IF_clk or posedge i_IF_rst) begin
        if (i_IF_rst) begin
            state     <= IDLE;
            pc_r      <= RESET_PC;
            fetch_pc  <= '0;
            buf_inst  <= NOP_INST;
            buf_pc    <= '0;
            buf_valid <= 1'b0;
            drop      <= 1'b0;
        end else begin
            // NOTE: non-blocking only; a later assignment in this block overrides an earlier one.
            if (consume) begin
                buf_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    state <= REQ;
                end
                REQ: begin
                    if (fire) begin
                        fetch_pc <= pc_r;
                        pc_r     <= pc_r + 64'd4;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_IF_imem_rvalid) begin
                        if (drop || i_IF_jump_flag) begin
                            drop <= 1'b0;
                        end else begin
                            buf_inst  <= i_IF_imem_rdata;
                            buf_pc    <= fetch_pc;
                            buf_valid <= 1'b1;
                        end
                        state <= REQ;
                    end else if (i_IF_jump_flag) begin
                        drop <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // The redirect comes last so it overrides both the PC increment and any buffer load.
            if (i_IF_jump_flag) begin
                pc_r      <= jump_target;
                buf_valid <= 1'b0;
            end
        end
    end

    assign o_IF_valid        = buf_valid;
    assign o_IF_inst         = buf_valid ? buf_inst : NOP_INST;
    assign o_IF_pc           = buf_valid ? buf_pc : 64'd0;
    assign o_IF_reg_rd_addr1 = o_IF_inst[19:15];
    assign o_IF_reg_rd_addr2 = o_IF_inst[24:20];

endmodule
